// File: rtl/video_pkg.sv
// Shared types and constants for the raster timing / test-pattern generator.
package video_pkg;

  // Test-pattern selection, latched once per frame.
  typedef enum logic [1:0] {
    STRIPES = 2'd0,
    BARS    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } pattern_mode_e;

  // Colour-bar table as {R,G,B} on/off masks; each bit fans out to a full channel.
  // Order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [2:0] BAR_MASK [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // Default 720x480 timing.
  localparam int unsigned DEF_H_ACTIVE = 720;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 62;
  localparam int unsigned DEF_H_BP     = 60;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 9;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 30;

endpackage

// File: rtl/video_pattern.sv
// Combinational test-pattern map: (x, y, mode, solid colour) -> {R,G,B}.
module video_pattern
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned CHK_LOG  = 4
) (
  input  logic [CNT_W-1:0]     x_i,
  input  logic [CNT_W-1:0]     y_i,
  input  pattern_mode_e        mode_i,
  input  logic [3*COLOR_W-1:0] solid_i,
  output logic [3*COLOR_W-1:0] rgb_o
);

  localparam int unsigned BAR_W_RAW = H_ACTIVE / 8;
  // Guard against a zero divisor for very narrow rasters.
  localparam int unsigned BAR_W     = (BAR_W_RAW == 0) ? 1 : BAR_W_RAW;

  localparam logic [CNT_W-1:0] STRIPE1 = CNT_W'(H_ACTIVE / 3);
  localparam logic [CNT_W-1:0] STRIPE2 = CNT_W'((2 * H_ACTIVE) / 3);
  localparam logic [CNT_W-1:0] BAR_DIV = CNT_W'(BAR_W);
  localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(7);

  logic [CNT_W-1:0] bar_idx_raw;
  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] chk;
  logic [2:0]       mask;

  // Select a colour mask per pattern and expand it to full-scale channels.
  always_comb begin
    bar_idx_raw = x_i / BAR_DIV;
    bar_idx     = (bar_idx_raw > BAR_MAX) ? 3'd7 : bar_idx_raw[2:0];
    chk         = (x_i >> CHK_LOG) ^ (y_i >> CHK_LOG);
    mask        = 3'b000;
    case (mode_i)
      STRIPES: begin
        if (x_i < STRIPE1)      mask = 3'b100;
        else if (x_i < STRIPE2) mask = 3'b010;
        else                    mask = 3'b001;
      end
      BARS:    mask = BAR_MASK[bar_idx];
      CHECKER: mask = chk[0] ? 3'b000 : 3'b111;
      default: mask = 3'b000;
    endcase
    if (mode_i == SOLID) rgb_o = solid_i;
    else rgb_o = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with registered sync/de/coords/sof
// and a per-frame latched test pattern.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned CHK_LOG  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 sof,
  output logic [3*COLOR_W-1:0] rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= 2 ** CNT_W) begin : g_h_total_too_big
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL >= 2 ** CNT_W) begin : g_v_total_too_big
    $error("V_TOTAL does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]     h_q, h_d, v_q, v_d;
  pattern_mode_e        mode_q, mode_d;
  logic [3*COLOR_W-1:0] solid_q, solid_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 de_q, de_d, sof_q, sof_d;
  logic [CNT_W-1:0]     x_q, x_d, y_q, y_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic [3*COLOR_W-1:0] pat_rgb;
  logic                 h_wrap, v_wrap;

  // The pattern sees the raw counters; rgb is gated by de, where x=h and y=v.
  video_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (CNT_W),
    .COLOR_W  (COLOR_W),
    .CHK_LOG  (CHK_LOG)
  ) u_pattern (
    .x_i     (h_q),
    .y_i     (v_q),
    .mode_i  (mode_q),
    .solid_i (solid_q),
    .rgb_o   (pat_rgb)
  );

  // Counter advance, frame-boundary pattern latch and next output values.
  always_comb begin
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    h_d     = h_wrap ? '0 : h_q + 1'b1;
    v_d     = v_q;
    if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;

    mode_d  = mode_q;
    solid_d = solid_q;
    if (h_wrap && v_wrap) begin
      mode_d  = pattern_mode_e'(mode);
      solid_d = solid_rgb;
    end

    de_d    = (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    x_d     = de_d ? h_q : x_q;
    y_d     = de_d ? v_q : y_q;
    sof_d   = de_d && (h_q == '0) && (v_q == '0);
    rgb_d   = de_d ? pat_rgb : '0;
  end

  // State and output registers; reset wins over ce, ce=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= STRIPES;
      solid_q <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      rgb_q   <= '0;
    end else if (ce) begin
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign x     = x_q;
  assign y     = y_q;
  assign sof   = sof_q;
  assign rgb   = rgb_q;

endmodule
